// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier sequencer.
// Holds the state encoding, control-bit indices and default widths.
package booth_pkg;

   localparam int COUNTER_BITS_DEF = 3;
   localparam int CTRL_WIDTH_DEF   = 8;

   localparam int C_INIT  = 0;
   localparam int C_LOADQ = 1;
   localparam int C_ADD   = 2;
   localparam int C_SUB   = 3;
   localparam int C_SHR   = 4;
   localparam int C_DUMPA = 5;
   localparam int C_DUMPQ = 6;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LOAD_M = 4'd1,
      LOAD_Q = 4'd2,
      TEST   = 4'd3,
      SHIFT  = 4'd4,
      CHECK  = 4'd5,
      OUT_A  = 4'd6,
      OUT_Q  = 4'd7,
      DONE   = 4'd8
   } state_t;

endpackage

// File: rtl/booth_sequencer.sv
// Control FSM for a radix-2 Booth multiplier datapath.
// Sequences load, add/sub/shift iterations and result dump.
module booth_sequencer
   import booth_pkg::*;
#(
   parameter int COUNTER_BITS = COUNTER_BITS_DEF,
   parameter int CTRL_WIDTH   = CTRL_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    beginsig,
   input  logic                    locksig,
   input  logic [1:0]              q_pair,
   input  logic [COUNTER_BITS-1:0] count,
   output logic [CTRL_WIDTH-1:0]   control,
   output logic                    endsig,
   output logic                    busy
);

   state_t state;
   state_t state_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = IDLE;
      control  = '0;
      case (state)
         IDLE: begin
            if (beginsig && !locksig) begin
               state_nx = LOAD_M;
            end else begin
               state_nx = IDLE;
            end
         end
         LOAD_M: begin
            state_nx        = LOAD_Q;
            control[C_INIT] = 1'b1;
         end
         LOAD_Q: begin
            state_nx         = TEST;
            control[C_LOADQ] = 1'b1;
         end
         TEST: begin
            state_nx = SHIFT;
            // Booth pair {Q0, Q-1}: 01 adds M, 10 subtracts M
            case (q_pair)
               2'b01: begin
                  control[C_ADD] = 1'b1;
               end
               2'b10: begin
                  control[C_ADD] = 1'b1;
                  control[C_SUB] = 1'b1;
               end
               default: begin
                  control = '0;
               end
            endcase
         end
         SHIFT: begin
            state_nx       = CHECK;
            control[C_SHR] = 1'b1;
         end
         CHECK: begin
            // counter wraps to zero after the last shift
            if (count == '0) begin
               state_nx = OUT_A;
            end else begin
               state_nx = TEST;
            end
         end
         OUT_A: begin
            state_nx         = OUT_Q;
            control[C_DUMPA] = 1'b1;
         end
         OUT_Q: begin
            state_nx         = DONE;
            control[C_DUMPQ] = 1'b1;
         end
         DONE: begin
            if (beginsig) begin
               state_nx = DONE;
            end else begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign endsig = (state == DONE);
   assign busy   = (state != IDLE) && (state != DONE);

endmodule

// File: doc/booth_sequencer.md
BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 The module SHALL have parameter COUNTER_BITS, default 3, the iteration-counter width; the multiply runs 2**COUNTER_BITS Booth iterations.
REQ-002 The module SHALL have parameter CTRL_WIDTH, default 8, the control-word width.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port rst  input  1  the reset, which is asynchronous and active-high.
REQ-005 The module SHALL have port beginsig  input  1  the start request.
REQ-006 The module SHALL have port locksig  input  1  the start lock; while high, no new operation is accepted.
REQ-007 The module SHALL have port q_pair  input  2  {Q[0], Q_-1} from the datapath, with Q[0] as the MSB.
REQ-008 The module SHALL have port count  input  COUNTER_BITS  the datapath iteration-counter value.
REQ-009 The module SHALL have port control  output  CTRL_WIDTH  the datapath control word: c0 initialises A, M, Q_-1 and the counter; c1 loads Q; c2 adds; c3 subtracts, qualifying c2; c4 shifts and increments the counter; c5 dumps A; c6 dumps Q; c7 is reserved and held at 0.
REQ-010 The module SHALL have port endsig  output  1  high while the result has completed.
REQ-011 The module SHALL have port busy  output  1  high in every state except IDLE and DONE.

Function
REQ-012 The module SHALL implement a single state register with states IDLE, LOAD_M, LOAD_Q, TEST, SHIFT, CHECK, OUT_A, OUT_Q and DONE.
REQ-013 The FSM SHALL move from IDLE to LOAD_M when beginsig=1 and locksig=0, and SHALL otherwise remain in IDLE.
REQ-014 The FSM SHALL move LOAD_M to LOAD_Q, LOAD_Q to TEST and TEST to SHIFT unconditionally.
REQ-015 The FSM SHALL move SHIFT to CHECK unconditionally.
REQ-016 The FSM SHALL move from CHECK to OUT_A when count==0, meaning the counter wrapped after 2**COUNTER_BITS shifts, and from CHECK to TEST otherwise.
REQ-017 The FSM SHALL move OUT_A to OUT_Q and OUT_Q to DONE unconditionally.
REQ-018 The FSM SHALL move from DONE to IDLE when beginsig=0, and SHALL remain in DONE while beginsig=1, so that a held beginsig cannot retrigger.
REQ-019 control SHALL be a combinational decode of the state: LOAD_M gives c0 only; LOAD_Q gives c1 only; SHIFT gives c4 only; OUT_A gives c5 only; OUT_Q gives c6 only; IDLE, CHECK and DONE give all zeros.
REQ-020 In TEST, control SHALL be c2 for q_pair=2'b01, c2|c3 for q_pair=2'b10, and zero for 2'b00 or 2'b11.
REQ-021 Exactly one of {c0, c1, c4, c5, c6} SHALL be asserted per cycle at most, and c3 SHALL never be asserted without c2.
REQ-022 endsig SHALL be 1 in DONE only.
REQ-023 Latency: counting the edge that samples the start as edge 0, LOAD_M SHALL be entered at edge 1 and DONE at edge 3+3*2**COUNTER_BITS+2, which is edge 29 for the default.
REQ-024 beginsig and locksig SHALL be ignored in all states other than IDLE and DONE; an operation in flight always completes.
REQ-025 An illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-026 rst=1 SHALL force the state to IDLE immediately, without waiting for a clock edge, including mid-operation.
REQ-027 While rst=1, control SHALL be 0, endsig SHALL be 0 and busy SHALL be 0.
REQ-028 After rst is released, the FSM SHALL require a fresh start condition and SHALL NOT resume an aborted operation.

Structure
REQ-029 The shared package booth_pkg SHALL hold the state enumeration, the control-bit index constants C_INIT=0, C_LOADQ=1, C_ADD=2, C_SUB=3, C_SHR=4, C_DUMPA=5 and C_DUMPQ=6, and the default widths.
REQ-030 The block SHALL be a single FSM with no sub-module; the output decode SHALL be in the same module.

Verification
REQ-031 Reset then beginsig=1, locksig=0, with a bench counter model -> c0 at cycle 1, c1 at cycle 2, exactly 8 c4 pulses, c5 then c6, endsig rises at edge 29.
REQ-032 In TEST with q_pair=01 -> control=8'h04; with q_pair=10 -> 8'h0C; with q_pair=00 or 11 -> 8'h00.
REQ-033 beginsig=1 and locksig=1 for 10 cycles -> state stays IDLE, control=0, busy=0.
REQ-034 rst pulsed mid-SHIFT on the 4th iteration -> control=0 and busy=0 without a clock edge; the next start runs a full 29-edge sequence.
REQ-035 beginsig held high through DONE -> endsig stays 1 and no c0 appears; beginsig dropped -> IDLE on the next edge.
REQ-036 An illegal state is forced via the bench -> IDLE one edge later with control=0.
